// File: rtl/pio_edge_servicer.sv
// Services PIO edge-capture interrupts: reads and clears edge-capture, queues captured bits as events.
// Optional periodic polling of edge-capture is built when PIO_EDGE_POLL_TIMER_EN is defined.
module pio_edge_servicer #(
    parameter int unsigned       DATA_W      = 4,
    parameter logic [DATA_W-1:0] MASK_INIT   = DATA_W'(4'hF),
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter int unsigned       POLL_PERIOD = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              irq,
    output logic              evt_valid,
    output logic [DATA_W-1:0] evt_data,
    input  logic              evt_ready,
    output logic              evt_overflow,
    input  logic              ovf_clr,
    output logic              busy
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [1:0]  ADDR_MASK = 2'd2;
    localparam logic [1:0]  ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_ADDR,
        RD_WAIT,
        CLEAR,
        PUSH
    } state_t;

    state_t            state;
    logic              init_go;
    logic [DATA_W-1:0] cap;
    logic              trig;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] head_nxt;
    logic              push;
    logic              pop;
    logic              full;
    logic              accept;

    // Upper read-data bits are never used by this block.
    logic unused_rd;
    assign unused_rd = ^m_readdata[31:DATA_W];

`ifdef PIO_EDGE_POLL_TIMER_EN
    localparam int unsigned POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    logic [POLL_W-1:0] poll_cnt;
    logic              poll_hit;
    logic              poll_pend;
    logic              svc_start;

    assign poll_hit  = (poll_cnt == POLL_W'(POLL_PERIOD - 1));
    assign trig      = irq | poll_hit | poll_pend;
    assign svc_start = (state == IDLE) && trig;

    // Poll counter restarts whenever a service begins; a missed terminal count stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else if (svc_start) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else if (poll_hit) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b1;
        end else begin
            poll_cnt  <= poll_cnt + POLL_W'(1);
        end
    end
`else
    assign trig = irq;
`endif

    // Service FSM; bus strobes are registered so they coincide with the state that owns them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT;
            init_go      <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 2'd0;
            m_writedata  <= 32'd0;
            busy         <= 1'b1;
            cap          <= '0;
        end else begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            busy         <= 1'b1;
            case (state)
                INIT: begin
                    if (!init_go) begin
                        init_go      <= 1'b1;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_MASK;
                        m_writedata  <= 32'(MASK_INIT);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (trig) begin
                        state        <= RD_ADDR;
                        m_chipselect <= 1'b1;
                        m_address    <= ADDR_EDGE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RD_ADDR: state <= RD_WAIT;
                RD_WAIT: begin
                    cap <= m_readdata[DATA_W-1:0];
                    if (m_readdata[DATA_W-1:0] == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state        <= CLEAR;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= ADDR_EDGE;
                        m_writedata  <= 32'hFFFF_FFFF;
                    end
                end
                CLEAR: state <= PUSH;
                PUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= INIT;
                    init_go <= 1'b0;
                end
            endcase
        end
    end

    assign push   = (state == PUSH);
    assign pop    = evt_valid & evt_ready;
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign accept = push & (~full | pop);

    // Next head is the freshly written entry only when it becomes the sole occupant.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        if (accept && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!accept && pop) begin
            count_nxt = count - CNT_W'(1);
        end
        head_nxt = mem[rd_ptr_nxt];
        if (accept && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = cap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_valid    <= 1'b0;
            evt_data     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            evt_valid <= (count_nxt != '0);
            evt_data  <= head_nxt;
            if (push && full && !pop) begin
                evt_overflow <= 1'b1;
            end else if (ovf_clr) begin
                evt_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= cap;
        end
    end

endmodule

// File: doc/pio_edge_servicer.md
PIO_EDGE_SERVICER -- requirements
Module: pio_edge_servicer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning the number of PIO input bits serviced.
REQ-002 SHALL have parameter MASK_INIT, default 4'hF, meaning the value written to the PIO interrupt-mask register after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of event entries; it SHALL be a power of two and at least 2.
REQ-004 SHALL have parameter POLL_PERIOD, default 50000, meaning the poll interval in clk cycles.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port m_address, output, 2 bits: PIO register select (2=irq mask, 3=edge capture).
REQ-008 SHALL have port m_chipselect, output, 1 bit: PIO access strobe.
REQ-009 SHALL have port m_write_n, output, 1 bit: active-low write strobe.
REQ-010 SHALL have port m_writedata, output, 32 bits: PIO write data.
REQ-011 SHALL have port m_readdata, input, 32 bits: PIO read data, registered by the PIO with a fixed latency of 1 cycle.
REQ-012 SHALL have port irq, input, 1 bit: PIO interrupt.
REQ-013 SHALL have ports evt_valid (output, 1 bit), evt_data (output, DATA_W bits) and evt_ready (input, 1 bit): the event stream.
REQ-014 SHALL have port evt_overflow, output, 1 bit: sticky flag indicating a dropped event.
REQ-015 SHALL have port ovf_clr, input, 1 bit: clears evt_overflow.
REQ-016 SHALL have port busy, output, 1 bit: high in every FSM state except IDLE.

Function
REQ-017 The FSM SHALL have states INIT, IDLE, RD_ADDR, RD_WAIT, CLEAR and PUSH.
REQ-018 INIT (one cycle) SHALL drive chipselect=1, write_n=0, address=2 and writedata=MASK_INIT zero-extended, then go to IDLE.
REQ-019 IDLE SHALL keep chipselect=0 and write_n=1, and SHALL go to RD_ADDR when irq=1 (or on a poll trigger, see Configuration).
REQ-020 RD_ADDR SHALL drive chipselect=1, write_n=1, address=3 for exactly one cycle, then go to RD_WAIT.
REQ-021 RD_WAIT SHALL capture m_readdata[DATA_W-1:0] into the internal register cap; if cap==0 it SHALL go to IDLE, otherwise to CLEAR.
REQ-022 CLEAR SHALL drive chipselect=1, write_n=0, address=3, writedata=32'hFFFFFFFF for one cycle, then go to PUSH.
REQ-023 PUSH SHALL enqueue cap and return to IDLE; because irq is already deasserted in this cycle, no spurious re-trigger SHALL occur.
REQ-024 Service latency SHALL be 4 cycles from irq sampled high in IDLE to event enqueued, and evt_valid SHALL rise on the cycle following PUSH when the FIFO was empty.
REQ-025 An edge captured by the PIO between RD_ADDR and CLEAR is lost; this is an accepted limitation and SHALL NOT be masked by the block.
REQ-026 The FIFO SHALL drive evt_valid = not empty and evt_data = head entry.
REQ-027 The FIFO SHALL pop when evt_valid and evt_ready are both high.
REQ-028 The FIFO SHALL hold its head entry stable while evt_valid=1 and evt_ready=0.
REQ-029 Push while full SHALL drop cap and set evt_overflow, except that push while full with a simultaneous pop SHALL be accepted.
REQ-030 Push and pop in the same cycle while not full SHALL leave the count unchanged.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 ovf_clr SHALL clear evt_overflow, and a set in the same cycle as ovf_clr SHALL win.
REQ-033 At most one PIO access SHALL be issued per cycle, and m_chipselect SHALL be 0 in IDLE, RD_WAIT and PUSH.

Reset
REQ-034 On reset_n=0 the block SHALL immediately set FSM=INIT, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, FIFO empty (evt_valid=0, evt_data=0), evt_overflow=0, busy=1 and poll counter=0.
REQ-035 A reset mid-transaction SHALL abandon the transaction, and on release the block SHALL rewrite the mask in INIT.

Configuration
REQ-036 Macro PIO_EDGE_POLL_TIMER_EN defined: a counter SHALL count 0..POLL_PERIOD-1 and raise a poll trigger at terminal count.
REQ-037 With the macro defined, the counter SHALL restart on each transition to RD_ADDR.
REQ-038 With the macro defined, a pending trigger SHALL be held until the FSM is in IDLE.
REQ-039 With the macro defined, polling SHALL service edges even when MASK_INIT=0.
REQ-040 Macro PIO_EDGE_POLL_TIMER_EN undefined: no counter SHALL be built, and only irq SHALL trigger service.

Verification
REQ-041 The bench SHALL cover: reset release -> one write cycle address=2, writedata=0x0000000F, then IDLE with busy=0.
REQ-042 The bench SHALL cover: irq high with readdata=0x5 -> read at address 3, write 0xFFFFFFFF at address 3, then evt_valid=1 with evt_data=4'h5, 4 cycles after irq.
REQ-043 The bench SHALL cover: irq high with readdata=0x0 -> read issued, no clear write, no event.
REQ-044 The bench SHALL cover: evt_ready=0 and 5 events 0x1..0x5 -> FIFO holds 0x1..0x4, evt_overflow=1; then ovf_clr -> evt_overflow=0.
REQ-045 The bench SHALL cover: FIFO full with evt_ready=1 during PUSH of 0x8 -> no overflow, and 0x8 appears as the 4th entry.
REQ-046 The bench SHALL cover, with PIO_EDGE_POLL_TIMER_EN and POLL_PERIOD=16, irq tied 0 and readdata=0x2: a read at address 3 every 16 cycles and event 0x2 pushed.
